// File: rtl/fc_wr_ctrl.sv
// Write-back stage for fully-connect results: captures one result vector, fetches a base
// address from fc_ctrl and writes the vector to the bus as AW/W/B bursts of up to burst_len.
module fc_wr_ctrl #(
  parameter int unsigned batch_size = 1,
  parameter int unsigned bias_size  = 1,
  parameter int unsigned burst_len  = 16
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [batch_size-1:0][bias_size-1:0][31:0]  FcNwc_result,
  input  logic                                        FcNwc_result_valid,
  output logic                                        NwcFc_result_ready,
  output logic                                        NwcNc_initAddrRq,
  input  logic [27:0]                                 NcNwc_initAddr,
  input  logic                                        NcNwc_initAddrEn,
  output logic                                        NwcNc_wr_end,
  output logic                                        NwcBus_awvalid,
  output logic [3:0]                                  NwcBus_awuserid,
  output logic [3:0]                                  NwcBus_awlen,
  output logic [27:0]                                 NwcBus_awaddr,
  input  logic                                        BusNwc_awready,
  output logic                                        NwcBus_wvalid,
  output logic [31:0]                                 NwcBus_wdata,
  output logic                                        NwcBus_wlast,
  input  logic                                        BusNwc_wready,
  input  logic                                        BusNwc_bvalid,
  input  logic [3:0]                                  BusNwc_bid,
  output logic                                        NwcBus_bready
);

  localparam logic [3:0]  AWID     = 4'b1010;
  localparam int unsigned RES_SIZE = batch_size * bias_size;
  localparam int unsigned CntW     = $clog2(RES_SIZE + 1);
  localparam int unsigned IdxW     = (RES_SIZE > 1) ? $clog2(RES_SIZE) : 1;
  localparam int unsigned BeatW    = (burst_len > 1) ? $clog2(burst_len) : 1;
  localparam int unsigned LenW     = $clog2(burst_len + 1);

  typedef enum logic [2:0] {StIdle, StAddr, StAw, StW, StB} state_e;

  state_e                       r_state;
  logic [RES_SIZE-1:0][31:0]    r_data;
  logic [CntW-1:0]              r_word_cnt;
  logic [BeatW-1:0]             r_beat;
  logic [LenW-1:0]              r_beats;
  logic [27:0]                  r_baddr;
  logic                         r_ready;
  logic                         r_rq;
  logic                         r_wr_end;
  logic                         r_awvalid;
  logic [3:0]                   r_awuserid;
  logic [3:0]                   r_awlen;
  logic [27:0]                  r_awaddr;
  logic                         r_wvalid;
  logic [31:0]                  r_wdata;
  logic                         r_wlast;
  logic                         r_bready;

  logic [31:0]                  w_remain;
  logic [LenW-1:0]              w_beats;
  logic [IdxW-1:0]              w_cur_idx;
  logic [IdxW-1:0]              w_nxt_idx;
  logic                         w_last_beat;

  always_comb begin
    w_remain    = 32'(RES_SIZE) - 32'(r_word_cnt);
    w_beats     = (w_remain < 32'(burst_len)) ? LenW'(w_remain) : LenW'(burst_len);
    w_cur_idx   = IdxW'(r_word_cnt);
    // Only consumed when another beat follows, so it never points past the vector.
    w_nxt_idx   = IdxW'(r_word_cnt + CntW'(1));
    w_last_beat = (32'(r_beat) + 32'd1 == 32'(r_beats));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_data     <= '0;
      r_word_cnt <= '0;
      r_beat     <= '0;
      r_beats    <= '0;
      r_baddr    <= '0;
      r_ready    <= 1'b0;
      r_rq       <= 1'b0;
      r_wr_end   <= 1'b0;
      r_awvalid  <= 1'b0;
      r_awuserid <= '0;
      r_awlen    <= '0;
      r_awaddr   <= '0;
      r_wvalid   <= 1'b0;
      r_wdata    <= '0;
      r_wlast    <= 1'b0;
      r_bready   <= 1'b0;
    end else begin
      r_wr_end <= 1'b0;
      unique case (r_state)
        StIdle: begin
          r_ready <= 1'b1;
          if (FcNwc_result_valid && r_ready) begin
            r_data     <= FcNwc_result;
            r_word_cnt <= '0;
            r_ready    <= 1'b0;
            r_rq       <= 1'b1;
            r_state    <= StAddr;
          end
        end
        StAddr: begin
          if (NcNwc_initAddrEn) begin
            r_baddr <= NcNwc_initAddr;
            r_rq    <= 1'b0;
            r_state <= StAw;
          end
        end
        StAw: begin
          // First cycle in AW sizes the burst; outputs then hold until awready.
          if (!r_awvalid) begin
            r_awvalid  <= 1'b1;
            r_awlen    <= 4'(w_beats - LenW'(1));
            r_awaddr   <= r_baddr;
            r_awuserid <= AWID;
            r_beats    <= w_beats;
          end else if (BusNwc_awready) begin
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b1;
            r_wdata   <= r_data[w_cur_idx];
            r_wlast   <= (r_beats == LenW'(1));
            r_beat    <= '0;
            r_state   <= StW;
          end
        end
        StW: begin
          if (BusNwc_wready) begin
            r_word_cnt <= r_word_cnt + CntW'(1);
            if (w_last_beat) begin
              r_wvalid <= 1'b0;
              r_wlast  <= 1'b0;
              r_bready <= 1'b1;
              r_state  <= StB;
            end else begin
              r_beat  <= r_beat + BeatW'(1);
              r_wdata <= r_data[w_nxt_idx];
              r_wlast <= (32'(r_beat) + 32'd2 == 32'(r_beats));
            end
          end
        end
        StB: begin
          if (BusNwc_bvalid && (BusNwc_bid == AWID)) begin
            r_bready <= 1'b0;
            r_baddr  <= r_baddr + 28'(r_beats);
            if (32'(r_word_cnt) == RES_SIZE) begin
              r_wr_end <= 1'b1;
              r_ready  <= 1'b1;
              r_state  <= StIdle;
            end else begin
              r_state <= StAw;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign NwcFc_result_ready = r_ready;
  assign NwcNc_initAddrRq   = r_rq;
  assign NwcNc_wr_end       = r_wr_end;
  assign NwcBus_awvalid     = r_awvalid;
  assign NwcBus_awuserid    = r_awuserid;
  assign NwcBus_awlen       = r_awlen;
  assign NwcBus_awaddr      = r_awaddr;
  assign NwcBus_wvalid      = r_wvalid;
  assign NwcBus_wdata       = r_wdata;
  assign NwcBus_wlast       = r_wlast;
  assign NwcBus_bready      = r_bready;

endmodule
